// File: rtl/counter_share_ctrl.sv
// counter_share_ctrl: two-requester arbiter and run sequencer for a shared up-counter.
// Each run counts 0..limit of the winner, then pulses done for one cycle.
// Define RR_ARB_EN for round-robin arbitration; otherwise req[0] has fixed priority.
module counter_share_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] limit0,
  input  logic [WIDTH-1:0] limit1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic [1:0]       done,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [1:0]       gnt_n, done_n;
  logic [WIDTH-1:0] q_n, lim_r, lim_n;
  logic             win;
  logic             g;

  assign g    = gnt[1];
  assign busy = (state == RUN) || (state == DONE);
  assign tc   = (state == RUN) && (q == lim_r);

`ifdef RR_ARB_EN
  logic last, last_n;

  // Contended request goes to the side not served last.
  always_comb begin
    if (req == 2'b11) win = ~last;
    else              win = req[1];
  end
`else
  // req[0] wins whenever it is set.
  always_comb begin
    win = ~req[0];
  end
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    done_n  = done;
    q_n     = q;
    lim_n   = lim_r;
`ifdef RR_ARB_EN
    last_n  = last;
`endif
    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          state_n = RUN;
          gnt_n   = win ? 2'b10 : 2'b01;
          q_n     = '0;
          lim_n   = win ? limit1 : limit0;
`ifdef RR_ARB_EN
          last_n  = win;
`endif
        end
      end
      RUN: begin
        // Abort outranks terminal count.
        if (!req[g]) begin
          state_n = IDLE;
          gnt_n   = '0;
        end else if (q == lim_r) begin
          state_n = DONE;
          gnt_n   = '0;
          done_n  = gnt;
        end else begin
          q_n = q + WIDTH'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
        done_n  = '0;
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
        done_n  = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= '0;
      done  <= '0;
      q     <= '0;
      lim_r <= '0;
`ifdef RR_ARB_EN
      last  <= 1'b1;
`endif
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      done  <= done_n;
      q     <= q_n;
      lim_r <= lim_n;
`ifdef RR_ARB_EN
      last  <= last_n;
`endif
    end
  end

endmodule

// File: tb/tb_counter_share_ctrl.sv
// Bench for counter_share_ctrl: directed vector table, hand sequences for
// arbitration order and async reset, then random traffic against a run-level model.
module tb_counter_share_ctrl;

  logic       clk;
  logic       rst_n;
  logic [1:0] req;
  logic [3:0] limit0, limit1;
  logic [1:0] gnt, done;
  logic       busy, tc;
  logic [3:0] q;

  int total = 0;
  int bad   = 0;

  counter_share_ctrl #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .limit0(limit0), .limit1(limit1),
    .gnt(gnt), .busy(busy), .done(done), .q(q), .tc(tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string nm, input logic [1:0] eg, input logic [1:0] ed,
                         input logic eb, input logic [3:0] eq, input logic et);
    chk({nm, ".gnt"},  32'(gnt),  32'(eg));
    chk({nm, ".done"}, 32'(done), 32'(ed));
    chk({nm, ".busy"}, 32'(busy), 32'(eb));
    chk({nm, ".q"},    32'(q),    32'(eq));
    chk({nm, ".tc"},   32'(tc),   32'(et));
  endtask

  // Run-level reference: who owns the counter, how far it has counted,
  // and whether a completion pulse is being shown this cycle.
  int m_own, m_srv, m_q, m_lim, m_last;
  bit m_cool;

  task automatic m_reset();
    m_own = -1; m_srv = 0; m_q = 0; m_lim = 0; m_last = 1; m_cool = 0;
  endtask

  function automatic int m_pick(input logic [1:0] r);
`ifdef RR_ARB_EN
    if (r == 2'b11) return (m_last == 0) ? 1 : 0;
    return r[1] ? 1 : 0;
`else
    return r[0] ? 0 : 1;
`endif
  endfunction

  task automatic m_step(input logic [1:0] r, input int l0, input int l1);
    int w;
    if (m_cool) begin
      m_cool = 0;
    end else if (m_own < 0) begin
      if (r != 2'b00) begin
        w = m_pick(r);
        m_own = w; m_q = 0; m_lim = (w == 1) ? l1 : l0; m_last = w;
      end
    end else if (!r[m_own]) begin
      m_own = -1;
    end else if (m_q == m_lim) begin
      m_srv = m_own; m_cool = 1; m_own = -1;
    end else begin
      m_q = m_q + 1;
    end
  endtask

  typedef struct {
    logic [1:0] req;
    logic [3:0] l0, l1;
    logic [1:0] gnt, done;
    logic       busy;
    logic [3:0] q;
    logic       tc;
  } vec_t;

  vec_t tbl[14];
  logic [1:0] gseq[$];
  logic [1:0] dseq[$];
  logic [1:0] prev_g;
  logic [1:0] exp_g;
  logic [1:0] exp_d;
  bit         hit;

  initial begin
    // limit0=3 run, limit0=0 run, limit1=9 run aborted at q=2
    tbl[0]  = '{2'b01, 4'd3, 4'd0, 2'b01, 2'b00, 1'b1, 4'd0, 1'b0};
    tbl[1]  = '{2'b01, 4'd3, 4'd0, 2'b01, 2'b00, 1'b1, 4'd1, 1'b0};
    tbl[2]  = '{2'b01, 4'd3, 4'd0, 2'b01, 2'b00, 1'b1, 4'd2, 1'b0};
    tbl[3]  = '{2'b01, 4'd3, 4'd0, 2'b01, 2'b00, 1'b1, 4'd3, 1'b1};
    tbl[4]  = '{2'b01, 4'd3, 4'd0, 2'b00, 2'b01, 1'b1, 4'd3, 1'b0};
    tbl[5]  = '{2'b00, 4'd3, 4'd0, 2'b00, 2'b00, 1'b0, 4'd3, 1'b0};
    tbl[6]  = '{2'b01, 4'd0, 4'd0, 2'b01, 2'b00, 1'b1, 4'd0, 1'b1};
    tbl[7]  = '{2'b01, 4'd0, 4'd0, 2'b00, 2'b01, 1'b1, 4'd0, 1'b0};
    tbl[8]  = '{2'b00, 4'd0, 4'd0, 2'b00, 2'b00, 1'b0, 4'd0, 1'b0};
    tbl[9]  = '{2'b10, 4'd0, 4'd9, 2'b10, 2'b00, 1'b1, 4'd0, 1'b0};
    tbl[10] = '{2'b10, 4'd0, 4'd9, 2'b10, 2'b00, 1'b1, 4'd1, 1'b0};
    tbl[11] = '{2'b10, 4'd0, 4'd9, 2'b10, 2'b00, 1'b1, 4'd2, 1'b0};
    tbl[12] = '{2'b00, 4'd0, 4'd9, 2'b00, 2'b00, 1'b0, 4'd2, 1'b0};
    tbl[13] = '{2'b00, 4'd0, 4'd9, 2'b00, 2'b00, 1'b0, 4'd2, 1'b0};

    rst_n = 1'b0; req = 2'b00; limit0 = '0; limit1 = '0;
    repeat (2) @(negedge clk);
    chk_all("in_reset", 2'b00, 2'b00, 1'b0, 4'd0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_all($sformatf("idle%0d", i), 2'b00, 2'b00, 1'b0, 4'd0, 1'b0);
    end

    // Directed vectors: drive at a negedge, check at the next one.
    for (int i = 0; i < 14; i++) begin
      req = tbl[i].req; limit0 = tbl[i].l0; limit1 = tbl[i].l1;
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].done, tbl[i].busy, tbl[i].q, tbl[i].tc);
    end

    // Both sides held requesting: record order of grants and done pulses.
    req = 2'b11; limit0 = 4'd1; limit1 = 4'd2; prev_g = 2'b00;
    for (int c = 0; c < 40 && (gseq.size() < 3 || dseq.size() < 3); c++) begin
      @(negedge clk);
      if (gnt != 2'b00 && prev_g == 2'b00) gseq.push_back(gnt);
      if (done != 2'b00) dseq.push_back(done);
      prev_g = gnt;
    end
    chk("rr.grants", 32'(gseq.size()), 32'd3);
    chk("rr.dones", 32'(dseq.size()), 32'd3);
    for (int k = 0; k < 3; k++) begin
`ifdef RR_ARB_EN
      exp_g = (k == 1) ? 2'b10 : 2'b01;
`else
      exp_g = 2'b01;
`endif
      exp_d = exp_g;
      chk($sformatf("rr.gnt%0d", k), (k < gseq.size()) ? 32'(gseq[k]) : 32'hx, 32'(exp_g));
      chk($sformatf("rr.done%0d", k), (k < dseq.size()) ? 32'(dseq[k]) : 32'hx, 32'(exp_d));
    end
    req = 2'b00;
    repeat (4) @(negedge clk);
    chk_all("rr.after", 2'b00, 2'b00, 1'b0, q, 1'b0);

    // Async reset mid-run at q=5, observed before the next posedge.
    req = 2'b01; limit0 = 4'd9; hit = 0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clk);
      if (gnt == 2'b01 && q == 4'd5) hit = 1;
    end
    chk("arst.reach_q5", 32'(hit), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_all("arst", 2'b00, 2'b00, 1'b0, 4'd0, 1'b0);
    @(negedge clk);
    req = 2'b00; rst_n = 1'b1;
    @(negedge clk);
    chk_all("arst.rel", 2'b00, 2'b00, 1'b0, 4'd0, 1'b0);

    // Random traffic against the run-level model.
    rst_n = 1'b0;
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      chk_all($sformatf("rnd%0d", c),
              (m_own < 0) ? 2'b00 : 2'(1 << m_own),
              m_cool ? 2'(1 << m_srv) : 2'b00,
              (m_own >= 0) || m_cool,
              4'(m_q),
              (m_own >= 0) && (m_q == m_lim));
      for (int b = 0; b < 2; b++)
        if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
      limit0 = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      limit1 = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      m_step(req, int'(limit0), int'(limit1));
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
